// File: rtl/vga_pixel_pipe.sv
// VGA pixel pipeline: timing counters, sync decode, scaled framebuffer addressing, test patterns.
// Define VGA_BORDER_EN to overlay BORDER_COLOR on the active-area edge in framebuffer mode.
module vga_pixel_pipe #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int CNT_W       = 10,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17,
`ifdef VGA_BORDER_EN
    parameter logic [11:0] BORDER_COLOR = 12'hf00,
`endif
    parameter int CHK_SHIFT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic [1:0]        mode,
    input  logic [11:0]       solid_color,
    input  logic [11:0]       fb_data,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd_en,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [11:0]       rgb,
    output logic              frame_start,
    output logic [CNT_W-1:0]  hcnt,
    output logic [CNT_W-1:0]  vcnt
);
    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHK   = 2'd2,
        MODE_SOLID = 2'd3
    } mode_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] ROW_MASK = CNT_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] FB_W    = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
    localparam int unsigned BAR_W         = H_ACTIVE / 8;
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [CNT_W-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, fb_addr_q, fb_addr_d;
    mode_t             mode_q, mode_d, s1_mode_q, s1_mode_d, s2_mode_q, s2_mode_d;
    logic              s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_first_q, s1_first_d;
    logic              s2_de_q, s2_de_d, s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d, s2_first_q, s2_first_d;
    logic [11:0]       s1_pat_q, s1_pat_d, s2_pat_q, s2_pat_d;
    logic              de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, frame_start_q, frame_start_d;
    logic [11:0]       rgb_q, rgb_d;
`ifdef VGA_BORDER_EN
    logic              s1_border_q, s1_border_d, s2_border_q, s2_border_d;
`endif

    logic        active0, first0, hs0, vs0;
    mode_t       mode0;
    logic [2:0]  bar_idx;
    logic [11:0] bar_rgb, pat0, fb_pix;

    always_comb begin
        active0 = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        first0  = (hcnt_q == '0) && (vcnt_q == '0);
        hs0     = (hcnt_q >= HS_BEG && hcnt_q < HS_END) ? HS_ON : ~HS_ON;
        vs0     = (vcnt_q >= VS_BEG && vcnt_q < VS_END) ? VS_ON : ~VS_ON;
        // The frame's first pixel already uses the newly sampled mode.
        mode0   = first0 ? mode_t'(mode) : mode_q;

        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (hcnt_q >= CNT_W'(k * BAR_W)) bar_idx = 3'(k);
        end
        bar_rgb = '0;
        case (bar_idx)
            3'd0: bar_rgb = 12'hfff;
            3'd1: bar_rgb = 12'hff0;
            3'd2: bar_rgb = 12'h0ff;
            3'd3: bar_rgb = 12'h0f0;
            3'd4: bar_rgb = 12'hf0f;
            3'd5: bar_rgb = 12'hf00;
            3'd6: bar_rgb = 12'h00f;
            3'd7: bar_rgb = 12'h000;
            default: bar_rgb = '0;
        endcase
        pat0 = '0;
        case (mode0)
            MODE_BARS:  pat0 = bar_rgb;
            MODE_CHK:   pat0 = (hcnt_q[CHK_SHIFT] ^ vcnt_q[CHK_SHIFT]) ? 12'hfff : 12'h000;
            MODE_SOLID: pat0 = solid_color;
            default:    pat0 = '0;
        endcase

`ifdef VGA_BORDER_EN
        fb_pix = s2_border_q ? BORDER_COLOR : fb_data;
`else
        fb_pix = fb_data;
`endif

        hcnt_d = hcnt_q;  vcnt_d = vcnt_q;  row_base_d = row_base_q;  mode_d = mode_q;
        fb_addr_d = fb_addr_q;
        s1_de_d = s1_de_q;  s1_hs_d = s1_hs_q;  s1_vs_d = s1_vs_q;  s1_first_d = s1_first_q;
        s1_mode_d = s1_mode_q;  s1_pat_d = s1_pat_q;
        s2_de_d = s2_de_q;  s2_hs_d = s2_hs_q;  s2_vs_d = s2_vs_q;  s2_first_d = s2_first_q;
        s2_mode_d = s2_mode_q;  s2_pat_d = s2_pat_q;
        de_d = de_q;  hsync_d = hsync_q;  vsync_d = vsync_q;  frame_start_d = frame_start_q;
        rgb_d = rgb_q;
`ifdef VGA_BORDER_EN
        s1_border_d = s1_border_q;  s2_border_d = s2_border_q;
`endif

        if (pix_ce) begin
            mode_d = mode0;
            // Row base steps by one framebuffer line each time the scaled row index advances.
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d     = '0;
                    row_base_d = '0;
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                    if ((vcnt_q & ROW_MASK) == ROW_MASK) row_base_d = row_base_q + FB_W;
                end
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end

            if (active0) fb_addr_d = row_base_q + ADDR_W'(hcnt_q >> SCALE_SHIFT);
            s1_de_d = active0;  s1_hs_d = hs0;  s1_vs_d = vs0;  s1_first_d = first0;
            s1_mode_d = mode0;  s1_pat_d = pat0;

            s2_de_d = s1_de_q;  s2_hs_d = s1_hs_q;  s2_vs_d = s1_vs_q;  s2_first_d = s1_first_q;
            s2_mode_d = s1_mode_q;  s2_pat_d = s1_pat_q;
`ifdef VGA_BORDER_EN
            s1_border_d = (hcnt_q == '0) || (hcnt_q == H_ACT - 1'b1) ||
                          (vcnt_q == '0) || (vcnt_q == V_ACT - 1'b1);
            s2_border_d = s1_border_q;
`endif

            de_d          = s2_de_q;
            hsync_d       = s2_hs_q;
            vsync_d       = s2_vs_q;
            frame_start_d = s2_first_q;
            rgb_d         = !s2_de_q ? 12'h000 : (s2_mode_q == MODE_FB) ? fb_pix : s2_pat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;  vcnt_q <= '0;  row_base_q <= '0;  mode_q <= MODE_FB;
            fb_addr_q <= '0;
            s1_de_q <= 1'b0;  s1_hs_q <= ~HS_ON;  s1_vs_q <= ~VS_ON;  s1_first_q <= 1'b0;
            s1_mode_q <= MODE_FB;  s1_pat_q <= '0;
            s2_de_q <= 1'b0;  s2_hs_q <= ~HS_ON;  s2_vs_q <= ~VS_ON;  s2_first_q <= 1'b0;
            s2_mode_q <= MODE_FB;  s2_pat_q <= '0;
            de_q <= 1'b0;  hsync_q <= ~HS_ON;  vsync_q <= ~VS_ON;  frame_start_q <= 1'b0;
            rgb_q <= '0;
`ifdef VGA_BORDER_EN
            s1_border_q <= 1'b0;  s2_border_q <= 1'b0;
`endif
        end else begin
            hcnt_q <= hcnt_d;  vcnt_q <= vcnt_d;  row_base_q <= row_base_d;  mode_q <= mode_d;
            fb_addr_q <= fb_addr_d;
            s1_de_q <= s1_de_d;  s1_hs_q <= s1_hs_d;  s1_vs_q <= s1_vs_d;  s1_first_q <= s1_first_d;
            s1_mode_q <= s1_mode_d;  s1_pat_q <= s1_pat_d;
            s2_de_q <= s2_de_d;  s2_hs_q <= s2_hs_d;  s2_vs_q <= s2_vs_d;  s2_first_q <= s2_first_d;
            s2_mode_q <= s2_mode_d;  s2_pat_q <= s2_pat_d;
            de_q <= de_d;  hsync_q <= hsync_d;  vsync_q <= vsync_d;  frame_start_q <= frame_start_d;
            rgb_q <= rgb_d;
`ifdef VGA_BORDER_EN
            s1_border_q <= s1_border_d;  s2_border_q <= s2_border_d;
`endif
        end
    end

    assign fb_addr     = fb_addr_q;
    assign fb_rd_en    = s1_de_q & pix_ce & ~rst;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;
    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Scoreboard bench for vga_pixel_pipe on a reduced 24x12 timing so whole frames stay short.
module tb_vga_pixel_pipe;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
    } out_t;

    // hsync active-low, vsync active-high in this configuration
    localparam out_t RST_OUT = '{de: 1'b0, hs: 1'b1, vs: 1'b0, fs: 1'b0, rgb: 12'h000};

    logic        clk = 1'b0;
    logic        rst, pix_ce;
    logic [1:0]  mode;
    logic [11:0] solid_color, fb_data, rgb;
    logic [16:0] fb_addr;
    logic        fb_rd_en, hsync, vsync, de, frame_start;
    logic [9:0]  hcnt, vcnt;

    out_t sb[$];
    out_t last_e = RST_OUT;
    int   n_checks = 0;
    int   n_fail = 0;
    int   mx = 0, my = 0;
    logic [1:0] mmode = 2'd0;
    logic prev_rst = 1'b1;
    logic [11:0] bars [8] = '{12'hfff, 12'hff0, 12'h0ff, 12'h0f0, 12'hf0f, 12'hf00, 12'h00f, 12'h000};

    vga_pixel_pipe #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(0), .VS_POL(1), .CNT_W(10), .SCALE_SHIFT(1), .ADDR_W(17), .CHK_SHIFT(1)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .mode(mode), .solid_color(solid_color),
        .fb_data(fb_data), .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .hsync(hsync),
        .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start), .hcnt(hcnt), .vcnt(vcnt)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM: returns its own address, one clock after the read strobe
    always @(posedge clk) if (fb_rd_en) fb_data <= fb_addr[11:0];

    function automatic out_t model(int x, int y, logic [1:0] m, logic [11:0] solid);
        out_t o;
        int   a;
        o.de  = (x < HA) && (y < VA);
        o.hs  = !(x >= 18 && x < 21);
        o.vs  = (y >= 9 && y < 11);
        o.fs  = (x == 0) && (y == 0);
        o.rgb = 12'h000;
        if (o.de) begin
            a = (y / 2) * (HA / 2) + (x / 2);
            case (m)
                2'd0:    o.rgb = 12'(a);
                2'd1:    o.rgb = bars[x / (HA / 8)];
                2'd2:    o.rgb = ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 12'hfff : 12'h000;
                default: o.rgb = solid;
            endcase
`ifdef VGA_BORDER_EN
            if (m == 2'd0 && (x == 0 || x == HA - 1 || y == 0 || y == VA - 1)) o.rgb = 12'hf00;
`endif
        end
        return o;
    endfunction

    task automatic step(input logic r, input logic ce, input logic [1:0] m, input logic [11:0] s);
        rst = r;  pix_ce = ce;  mode = m;  solid_color = s;
        if (r) begin
            sb.delete();
            sb.push_back(RST_OUT);
        end else begin
            if (prev_rst) begin
                mx = 0;  my = 0;  mmode = 2'd0;
                sb.push_back(RST_OUT);
                sb.push_back(RST_OUT);
            end
            n_checks++;
            if (hcnt !== 10'(mx) || vcnt !== 10'(my)) begin
                n_fail++;
                $display("FAIL counters t=%0t got h=%0d v=%0d exp h=%0d v=%0d", $time, hcnt, vcnt, mx, my);
            end
            if (ce) begin
                if (mx == 0 && my == 0) mmode = m;
                sb.push_back(model(mx, my, mmode, s));
                mx++;
                if (mx == HT) begin
                    mx = 0;
                    my++;
                    if (my == VT) my = 0;
                end
            end
        end
        prev_rst = r;
        @(negedge clk);
    endtask

    initial begin : monitor
        out_t g, e;
        forever begin
            @(posedge clk);
            if (rst || pix_ce) begin
                #1;
                g = {de, hsync, vsync, frame_start, rgb};
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty t=%0t got de=%b hs=%b vs=%b fs=%b rgb=%h", $time, g.de, g.hs, g.vs, g.fs, g.rgb);
                end else begin
                    e = sb.pop_front();
                    last_e = e;
                    if (g !== e) begin
                        n_fail++;
                        $display("FAIL output t=%0t got de=%b hs=%b vs=%b fs=%b rgb=%h exp de=%b hs=%b vs=%b fs=%b rgb=%h",
                                 $time, g.de, g.hs, g.vs, g.fs, g.rgb, e.de, e.hs, e.vs, e.fs, e.rgb);
                    end
                end
            end else begin
                #1;
                g = {de, hsync, vsync, frame_start, rgb};
                n_checks++;
                if (g !== last_e || fb_rd_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold t=%0t got rgb=%h de=%b hs=%b rd_en=%b exp rgb=%h de=%b hs=%b rd_en=0",
                             $time, g.rgb, g.de, g.hs, fb_rd_en, last_e.rgb, last_e.de, last_e.hs);
                end
            end
        end
    end

    initial begin : stimulus
        repeat (3) step(1'b1, 1'b1, 2'd2, 12'h000);
        repeat (2 * FR) step(1'b0, 1'b1, 2'd2, 12'h000);
        repeat (FR) step(1'b0, 1'b1, 2'd0, 12'h000);
        repeat (FR) step(1'b0, 1'b1, 2'd1, 12'h000);
        for (int i = 0; i < 2 * FR; i++) step(1'b0, (i % 2) == 0, 2'd1, 12'h000);
        // mode request flips mid-frame; bars must persist until the next frame
        repeat (4 * HT) step(1'b0, 1'b1, 2'd1, 12'h000);
        repeat (2 * FR - 4 * HT) step(1'b0, 1'b1, 2'd3, 12'($urandom_range(0, 4095)));
        repeat (5 * HT + 10) step(1'b0, 1'b1, 2'd2, 12'h000);
        repeat (2) step(1'b1, 1'b1, 2'd2, 12'h000);
        repeat (FR + 10) step(1'b0, 1'b1, 2'd2, 12'h000);
        repeat (3) step(1'b0, 1'b0, 2'd2, 12'h000);
        n_checks++;
        if (sb.size() != 2) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending exp 2", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_pixel_pipe.md
Name: vga_pixel_pipe

Overview:
- Parametrised VGA pixel pipeline: timing counters, sync generation, framebuffer read-address generation with integer down-scaling, selectable test patterns.
- Sits between a 1-cycle-latency synchronous framebuffer RAM (read port) and the VGA pins.
- Supports any mode via parameters.
- Pixel-clock enable lets it run from a faster system clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- SCALE_SHIFT, 1, framebuffer pixel = 2^SCALE_SHIFT screen pixels per axis
- ADDR_W, 17, fb_addr width
- CHK_SHIFT, 3, checkerboard square = 2^CHK_SHIFT pixels

Ports:
- clk, in, 1, pixel/system clock
- rst, in, 1, synchronous active-high reset
- pix_ce, in, 1, pixel advance enable; tie 1 for clk = pixel clock
- mode, in, 2, 0 framebuffer / 1 colour bars / 2 checkerboard / 3 solid
- solid_color, in, 12, RGB444 for mode 3
- fb_data, in, 12, RAM read data; valid 1 clk after fb_addr
- fb_addr, out, ADDR_W, framebuffer read address
- fb_rd_en, out, 1, read strobe, high when stage-1 pixel is active and pix_ce=1
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, active video
- rgb, out, 12, pixel colour {R[3:0],G[3:0],B[3:0]}
- frame_start, out, 1, one-clk pulse with first pixel of frame on outputs
- hcnt, out, CNT_W, stage-0 horizontal count
- vcnt, out, CNT_W, stage-0 vertical count

Behaviour:
- Timing: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous.
- Counters (stage 0): advance only when pix_ce=1.
  - hcnt 0..H_TOTAL-1, then wraps to 0 and increments vcnt.
  - vcnt 0..V_TOTAL-1, then wraps to 0.
- Decode:
  - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - hsync active for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync active analogously on vcnt.
  - Active level = HS_POL/VS_POL.
- Pipeline, three pix_ce-qualified stages:
  - Stage 1 registers fb_addr, pattern inputs and sync/de.
  - Stage 2 consumes fb_data.
  - Outputs registered. Output latency is exactly 3 enabled cycles after the counter value.
  - All pipeline registers hold when pix_ce=0.
- Address: fb_addr = (vcnt>>SCALE_SHIFT)*(H_ACTIVE>>SCALE_SHIFT) + (hcnt>>SCALE_SHIFT), truncated to ADDR_W.
  - Implementation uses an incremental row base; no multiplier.
  - fb_addr holds its last value outside the active region.
- Mode is sampled only at hcnt=0, vcnt=0 (frame boundary). A mid-frame change takes effect on the next frame.
- Colour when de=1:
  - mode 0: fb_data.
  - mode 1: 8 equal bars of width H_ACTIVE/8, left to right: fff, ff0, 0ff, 0f0, f0f, f00, 00f, 000.
  - mode 2: (hcnt[CHK_SHIFT]^vcnt[CHK_SHIFT]) ? fff : 000.
  - mode 3: solid_color, sampled per pixel.
- Colour when de=0: rgb forced to 000.
- frame_start: 1 for exactly one enabled cycle, coincident with de of pixel (0,0) on the outputs.
- Reset values:
  - hcnt = vcnt = 0, fb_addr = 0, fb_rd_en = 0, de = 0, rgb = 000, frame_start = 0.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - Latched mode = 0.
- Reset mid-frame: pipeline flushed. First cycle after rst deasserts, counters at 0,0. First active pixel reaches the outputs 3 enabled cycles later.
- rst overrides pix_ce.

Optional Feature:
- Macro: VGA_BORDER_EN.
- Defined: in mode 0, pixels with hcnt==0, hcnt==H_ACTIVE-1, vcnt==0 or vcnt==V_ACTIVE-1 output BORDER_COLOR (parameter, default f00) instead of fb_data. fb_rd_en is unchanged.
- Undefined: no border logic; mode 0 outputs fb_data everywhere.

Test Plan:
- Defaults, pix_ce=1, mode 2, run 2 frames -> hsync low for exactly 96 clk per line, starting 3 clk after hcnt=656. vsync low for 2 lines (vcnt 490–491 delayed 3 clk). Period 800×525 = 420000 clk. frame_start once per frame.
- Mode 0, RAM model returning addr[11:0] with 1-clk latency -> pixel (x=5,y=3) outputs rgb = 1*320+2 = 0x142. Adjacent x=4,5 share the same address. rgb = 000 whenever de=0.
- Mode 1 -> rgb = fff for x 0–79, ff0 for x 80–159, ..., 000 for x 560–639.
- pix_ce toggling 1,0,1,0 -> outputs identical to the pix_ce=1 run, stretched 2×. hsync width = 192 clk.
- Mode changed 1→3 at vcnt=100 -> colour bars continue to end of frame. Next frame is solid_color throughout.
- rst asserted at hcnt=300, vcnt=200 for 2 clk -> outputs at reset values while asserted. After release, counters restart at 0,0. frame_start appears 3 clk after release.
